// File: rtl/jpeg_coef_pkg.sv
// Shared constants and FSM encodings for the JPEG coefficient block sequencer.
package jpeg_coef_pkg;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned COEF_WIDTH = 8;
  localparam int unsigned ZRL_RUN    = 16;

  localparam logic [5:0] LAST_INDEX   = 6'(BLOCK_SIZE - 1);
  localparam logic [3:0] EOB_RUN      = 4'd0;
  localparam logic [3:0] ZRL_RUN_CODE = 4'd15;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StZfill   = 2'd1;
  localparam logic [1:0] StValue   = 2'd2;
  localparam logic [1:0] StEobfill = 2'd3;

  // Clamp a wide signed sum into the signed coefficient range.
  function automatic logic [COEF_WIDTH-1:0] sat_coef(input logic signed [12:0] x);
    if (x > 13'sd127) begin
      return 8'h7f;
    end else if (x < -13'sd128) begin
      return 8'h80;
    end else begin
      return x[COEF_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/coef_block_sequencer_number_decoder.sv
// Number_Decoder: converts JPEG size-coded magnitude bits (s bits, right-aligned) to a signed value.
module Number_Decoder (
  input  logic        [3:0]  s_value,
  input  logic        [11:0] coded_number,
  output logic signed [11:0] decoded_number
);

  logic [15:0] mask;
  logic [15:0] ext;
  logic [15:0] res;
  logic [3:0]  s_m1;
  logic        msb;

  always_comb begin
    mask = (16'd1 << s_value) - 16'd1;
    ext  = {4'd0, coded_number} & mask;
    s_m1 = s_value - 4'd1;
    msb  = ext[s_m1];
    // A clear leading bit marks a negative value: v = bits - (2^s - 1).
    if (s_value == 4'd0) begin
      res = 16'd0;
    end else if (msb) begin
      res = ext;
    end else begin
      res = ext - mask;
    end
    decoded_number = $signed(res[11:0]);
  end

endmodule

// File: rtl/coef_block_sequencer.sv
// Expands (run, size, bits) symbols into 64 zig-zag indexed coefficients per block.
// Optional DC prediction with saturation is enabled by defining JPEG_DC_PREDICT_EN.
module coef_block_sequencer
  import jpeg_coef_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic                  sym_is_dc,
  input  logic [3:0]            sym_run,
  input  logic [3:0]            sym_size,
  input  logic [11:0]           sym_bits,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [5:0]            coef_index,
  output logic [COEF_WIDTH-1:0] coef_value,
  output logic                  coef_last,
  output logic                  err
);

  logic [1:0]            state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [3:0]            size_q, size_d;
  logic [11:0]           bits_q, bits_d;
  logic                  live_q;
  logic                  valid_q, valid_d;
  logic [5:0]            index_q, index_d;
  logic [COEF_WIDTH-1:0] value_q, value_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic                  free, accept, in_idle;
  logic                  load, load_dc, err_set;
  logic [COEF_WIDTH-1:0] load_val, ac_val, dc_val;
  logic [3:0]            dec_size;
  logic [11:0]           dec_bits;
  logic signed [11:0]    dec_out;
  logic                  unused_dec;

  // In IDLE the decoder sees the incoming symbol so the first beat leaves one cycle after accept.
  assign in_idle  = (state_q == StIdle);
  assign dec_size = in_idle ? sym_size : size_q;
  assign dec_bits = in_idle ? sym_bits : bits_q;

  Number_Decoder u_number_decoder (
    .s_value        (dec_size),
    .coded_number   (dec_bits),
    .decoded_number (dec_out)
  );

  assign ac_val     = dec_out[COEF_WIDTH-1:0];
  assign unused_dec = ^dec_out[11:COEF_WIDTH];

`ifdef JPEG_DC_PREDICT_EN
  logic signed [COEF_WIDTH-1:0] pred_q, pred_d;
  logic                         isdc_q, isdc_d;
  logic signed [12:0]           dc_sum;

  assign dc_sum = 13'(pred_q) + 13'(dec_out);
  assign dc_val = sat_coef(dc_sum);
`else
  assign dc_val = ac_val;
`endif

  assign free      = !valid_q || coef_ready;
  assign sym_ready = live_q && in_idle && free && !restart;
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    size_d   = size_q;
    bits_d   = bits_q;
    load     = 1'b0;
    load_dc  = 1'b0;
    load_val = '0;
    err_set  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          size_d = sym_size;
          bits_d = sym_bits;
          if (sym_is_dc) begin
            err_set  = (idx_q != 6'd0) || (sym_size > 4'd7);
            load     = 1'b1;
            load_dc  = 1'b1;
            load_val = dc_val;
          end else if (idx_q == 6'd0) begin
            // AC where a DC is expected (includes EOB after a completed block): dropped.
            err_set = 1'b1;
          end else if (sym_size == 4'd0 && sym_run == EOB_RUN) begin
            load    = 1'b1;
            state_d = (idx_q == LAST_INDEX) ? StIdle : StEobfill;
          end else if (sym_size == 4'd0 && sym_run == ZRL_RUN_CODE) begin
            load   = 1'b1;
            cnt_d  = 4'(ZRL_RUN - 1);
            pend_d = 1'b0;
            if (idx_q == LAST_INDEX) err_set = 1'b1;
            else                     state_d = StZfill;
          end else begin
            err_set = (sym_size > 4'd7);
            load    = 1'b1;
            if (sym_run == 4'd0) begin
              load_val = ac_val;
            end else begin
              cnt_d  = sym_run - 4'd1;
              pend_d = 1'b1;
              if (idx_q == LAST_INDEX)   err_set = 1'b1;
              else if (sym_run == 4'd1)  state_d = StValue;
              else                       state_d = StZfill;
            end
          end
        end
      end
      StZfill: begin
        if (free) begin
          load  = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (idx_q == LAST_INDEX) begin
            err_set = (cnt_q != 4'd1) || pend_q;
            state_d = StIdle;
          end else if (cnt_q == 4'd1) begin
            state_d = pend_q ? StValue : StIdle;
          end
        end
      end
      StValue: begin
        if (free) begin
          load     = 1'b1;
          load_val = ac_val;
          state_d  = StIdle;
        end
      end
      default: begin
        if (free) begin
          load = 1'b1;
          if (idx_q == LAST_INDEX) state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    value_d = value_q;
    last_d  = last_q;
    err_d   = err_q | err_set;
`ifdef JPEG_DC_PREDICT_EN
    isdc_d = isdc_q;
    pred_d = pred_q;
    if (valid_q && coef_ready && isdc_q) pred_d = value_q;
`endif
    if (load) begin
      valid_d = 1'b1;
      index_d = idx_q;
      value_d = load_val;
      last_d  = (idx_q == LAST_INDEX);
`ifdef JPEG_DC_PREDICT_EN
      isdc_d = load_dc;
`endif
    end else if (coef_ready) begin
      valid_d = 1'b0;
    end
    if (restart) begin
      valid_d = 1'b0;
      index_d = '0;
      value_d = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
`ifdef JPEG_DC_PREDICT_EN
      isdc_d = 1'b0;
      pred_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      size_q  <= '0;
      bits_q  <= '0;
      live_q  <= 1'b0;
      valid_q <= 1'b0;
      index_q <= '0;
      value_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      size_q  <= size_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      index_q <= index_d;
      value_q <= value_d;
      last_q  <= last_d;
      err_q   <= err_d;
      if (restart) begin
        state_q <= StIdle;
        idx_q   <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        idx_q   <= load ? idx_q + 6'd1 : idx_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
      end
    end
  end

`ifdef JPEG_DC_PREDICT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_q <= '0;
      isdc_q <= 1'b0;
    end else begin
      pred_q <= pred_d;
      isdc_q <= isdc_d;
    end
  end
`endif

  assign coef_valid = valid_q;
  assign coef_index = index_q;
  assign coef_value = value_q;
  assign coef_last  = last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_coef_block_sequencer.sv
// Directed bench for coef_block_sequencer: symbol table with expected beat runs plus stall/restart cases.
module tb_coef_block_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_is_dc;
  logic [3:0]  sym_run;
  logic [3:0]  sym_size;
  logic [11:0] sym_bits;
  logic        coef_valid;
  logic        coef_ready;
  logic [5:0]  coef_index;
  logic [7:0]  coef_value;
  logic        coef_last;
  logic        err;

  coef_block_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    (restart),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_is_dc  (sym_is_dc),
    .sym_run    (sym_run),
    .sym_size   (sym_size),
    .sym_bits   (sym_bits),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_index (coef_index),
    .coef_value (coef_value),
    .coef_last  (coef_last),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        dc;
    bit [3:0]  run;
    bit [3:0]  size;
    bit [11:0] bits;
    int        first;
    int        beats;
    bit        has_val;
    int        val;
  } vec_t;

  typedef struct {
    int idx;
    int val;
    int last;
  } beat_t;

  vec_t  vecs[$];
  beat_t beats_q[$];
  int    errors = 0;
  int    checks = 0;

  always @(negedge clk) begin
    if (reset_n && coef_valid && coef_ready)
      beats_q.push_back('{int'(coef_index), int'($signed(coef_value)), int'(coef_last)});
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input bit dc, input bit [3:0] run, input bit [3:0] size,
                         input bit [11:0] bits, input int first, input int beats,
                         input bit has_val, input int val);
    vec_t v;
    v.dc = dc; v.run = run; v.size = size; v.bits = bits;
    v.first = first; v.beats = beats; v.has_val = has_val; v.val = val;
    vecs.push_back(v);
  endtask

  task automatic send(input bit dc, input bit [3:0] run, input bit [3:0] size,
                      input bit [11:0] bits);
    bit done = 1'b0;
    @(posedge clk); #1;
    sym_is_dc = dc; sym_run = run; sym_size = size; sym_bits = bits; sym_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (sym_ready) done = 1'b1;
    end
    if (!done) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (sym_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic check_beats(input int first, input int nb, input bit has_val, input int val);
    beat_t b;
    int    n;
    n = beats_q.size();
    chk("beat_count", n, nb);
    for (int i = 0; i < n; i++) begin
      int ei;
      b = beats_q.pop_front();
      if (i < nb) begin
        ei = (first + i) % 64;
        chk("beat_index", b.idx, ei);
        chk("beat_value", b.val, (has_val && i == nb - 1) ? val : 0);
        chk("beat_last", b.last, (ei == 63) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_idx, snap_val;
    int dc_a, dc_b, dc_c, dc_d, dc_e, dc_f;
`ifdef JPEG_DC_PREDICT_EN
    dc_a = -10; dc_b = -10; dc_c = -10; dc_d = 90; dc_e = 127; dc_f = 127;
`else
    dc_a = -10; dc_b = 0; dc_c = 0; dc_d = 100; dc_e = 100; dc_f = 0;
`endif
    // dc, run, size, bits, first index, beats, has value, final value
    add_vec(1, 0, 4, 12'b0101,    0,  1, 1, dc_a);
    add_vec(0, 0, 0, 12'd0,       1, 63, 0, 0);
    add_vec(1, 0, 0, 12'd0,       0,  1, 1, dc_b);
    add_vec(0, 2, 1, 12'b1,       1,  3, 1, 1);
    add_vec(0, 0, 2, 12'b00,      4,  1, 1, -3);
    add_vec(0, 0, 0, 12'd0,       5, 59, 0, 0);
    add_vec(1, 0, 0, 12'd0,       0,  1, 1, dc_c);
    add_vec(0, 15, 0, 12'd0,      1, 16, 0, 0);
    add_vec(0, 15, 0, 12'd0,     17, 16, 0, 0);
    add_vec(0, 15, 0, 12'd0,     33, 16, 0, 0);
    add_vec(0, 14, 1, 12'b0,     49, 15, 1, -1);
    add_vec(1, 0, 7, 12'b1100100, 0,  1, 1, dc_d);
    add_vec(0, 0, 0, 12'd0,       1, 63, 0, 0);
    add_vec(1, 0, 7, 12'b1100100, 0,  1, 1, dc_e);
    add_vec(0, 0, 0, 12'd0,       1, 63, 0, 0);

    reset_n = 1'b0; restart = 1'b0; sym_valid = 1'b0; sym_is_dc = 1'b0;
    sym_run = '0; sym_size = '0; sym_bits = '0; coef_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_coef_valid", int'(coef_valid), 0);
    chk("rst_coef_index", int'(coef_index), 0);
    chk("rst_coef_value", int'(coef_value), 0);
    chk("rst_coef_last", int'(coef_last), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].dc, vecs[i].run, vecs[i].size, vecs[i].bits);
      wait_idle();
      check_beats(vecs[i].first, vecs[i].beats, vecs[i].has_val, vecs[i].val);
    end
    chk("err_after_table", int'(err), 0);

    // Stall during ZFILL with coef_ready pattern 1-0-0-1.
    send(1, 0, 0, 12'd0);
    wait_idle();
    check_beats(0, 1, 1, dc_f);
    send(0, 4, 1, 12'b1);
    @(negedge clk);
    chk("stall_first_idx", int'(coef_index), 1);
    @(posedge clk); #1;
    coef_ready = 1'b0;
    @(negedge clk);
    snap_idx = int'(coef_index);
    snap_val = int'($signed(coef_value));
    chk("stall_idx", snap_idx, 2);
    chk("stall_valid", int'(coef_valid), 1);
    chk("stall_sym_ready", int'(sym_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_idx", int'(coef_index), snap_idx);
    chk("hold_val", int'($signed(coef_value)), snap_val);
    chk("hold_valid", int'(coef_valid), 1);
    chk("hold_sym_ready", int'(sym_ready), 0);
    @(posedge clk); #1;
    coef_ready = 1'b1;
    wait_idle();
    check_beats(1, 5, 1, 1);

    // Abort mid-block, then an AC symbol at index 0 is a protocol error.
    @(posedge clk); #1; restart = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    send(0, 0, 1, 12'b1);
    @(negedge clk); #1;
    chk("ac_at_0_err", int'(err), 1);
    chk("ac_at_0_beats", beats_q.size(), 0);

    // Restart coincident with a valid symbol: symbol not taken, err cleared.
    @(posedge clk); #1;
    restart = 1'b1; sym_valid = 1'b1; sym_is_dc = 1'b1; sym_run = '0;
    sym_size = 4'd1; sym_bits = 12'd0;
    @(negedge clk);
    chk("restart_sym_ready", int'(sym_ready), 0);
    @(posedge clk); #1;
    restart = 1'b0; sym_valid = 1'b0;
    @(negedge clk); #1;
    chk("restart_err", int'(err), 0);
    chk("restart_valid", int'(coef_valid), 0);
    chk("restart_beats", beats_q.size(), 0);
    send(1, 0, 1, 12'b0);
    wait_idle();
    check_beats(0, 1, 1, -1);
    send(0, 0, 0, 12'd0);
    wait_idle();
    check_beats(1, 63, 0, 0);
    chk("final_err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
